// File: rtl/gcd_binary_if.sv
// ap_* control handshake plus operand/result bus for the binary GCD accelerator.
// The requester (master) drives ap_start/a/b; the accelerator (slave) drives status and results.
interface gcd_binary_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             ap_start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ap_idle;
  logic             ap_ready;
  logic             ap_done;
  logic [WIDTH-1:0] ap_return;
  logic [CNT_W-1:0] ap_cycles;

  modport master (
    output ap_start, a, b,
    input  ap_idle, ap_ready, ap_done, ap_return, ap_cycles
  );

  modport slave (
    input  ap_start, a, b,
    output ap_idle, ap_ready, ap_done, ap_return, ap_cycles
  );
endinterface

// File: rtl/gcd_binary.sv
// Binary (Stein) GCD, one shift or subtract per clock; ap_done R+1 cycles after ap_ready (R = RUN cycles).
// No backpressure: ap_start is only sampled in IDLE, never queued; results hold until the next ap_done.
module gcd_binary #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  gcd_binary_if.slave bus
);
  localparam int KW = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0]    K_ONE   = {{(KW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] u, u_nxt;
  logic [WIDTH-1:0] v, v_nxt;
  logic [KW-1:0]    k, k_nxt;
  logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
  logic [CNT_W-1:0] run_cnt_inc;
  logic [WIDTH-1:0] ret, ret_nxt;
  logic [CNT_W-1:0] cycles, cycles_nxt;

  assign run_cnt_inc = (run_cnt == CNT_MAX) ? CNT_MAX : run_cnt + CNT_ONE;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state   <= IDLE;
      u       <= '0;
      v       <= '0;
      k       <= '0;
      run_cnt <= '0;
      ret     <= '0;
      cycles  <= '0;
    end else begin
      state   <= state_nxt;
      u       <= u_nxt;
      v       <= v_nxt;
      k       <= k_nxt;
      run_cnt <= run_cnt_nxt;
      ret     <= ret_nxt;
      cycles  <= cycles_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    u_nxt       = u;
    v_nxt       = v;
    k_nxt       = k;
    run_cnt_nxt = run_cnt;
    ret_nxt     = ret;
    cycles_nxt  = cycles;
    case (state)
      IDLE: begin
        if (bus.ap_start) begin
          u_nxt       = bus.a;
          v_nxt       = bus.b;
          k_nxt       = '0;
          run_cnt_nxt = '0;
          state_nxt   = CHECK;
        end
      end
      CHECK: begin
        if (u == '0 || v == '0) begin
          ret_nxt    = u | v;
          cycles_nxt = '0;
          state_nxt  = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        run_cnt_nxt = run_cnt_inc;
        // Priority order matters: v==0 is only tested once u is known odd.
        if (!u[0] && !v[0]) begin
          u_nxt = u >> 1;
          v_nxt = v >> 1;
          k_nxt = k + K_ONE;
        end else if (!u[0]) begin
          u_nxt = u >> 1;
        end else if (v == '0) begin
          ret_nxt    = u << k;
          cycles_nxt = run_cnt_inc;
          state_nxt  = DONE;
        end else if (!v[0]) begin
          v_nxt = v >> 1;
        end else if (u > v) begin
          u_nxt = v;
          v_nxt = u - v;
        end else begin
          v_nxt = v - u;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ap_idle   = (state == IDLE);
  assign bus.ap_ready  = (state == CHECK);
  assign bus.ap_done   = (state == DONE);
  assign bus.ap_return = ret;
  assign bus.ap_cycles = cycles;
endmodule
